// File: rtl/arbiter_pkg.sv
// Shared helpers for the bus arbiter: index width and the one-hot check used by
// the optional simulation checks.
package arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic onehot_or_zero(input logic [63:0] vec);
    return (vec & (vec - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/arbiter_prio_sel.sv
// Combinational masked priority selector: first set request at or after the
// start index (wrapping) wins.
module arbiter_prio_sel
  import arbiter_pkg::*;
#(
  parameter int unsigned NumOfRequesters = 4,
  parameter int unsigned IdxW            = idx_width(NumOfRequesters)
) (
  input  logic [NumOfRequesters-1:0] req,
  input  logic [IdxW-1:0]            start,
  output logic [NumOfRequesters-1:0] winner,
  output logic [IdxW-1:0]            winner_idx
);

  always_comb begin
    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] sel;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    sel        = '0;
    for (int unsigned off = 0; off < NumOfRequesters; off++) begin
      cand = 32'(start) + off;
      if (cand >= NumOfRequesters) cand = cand - NumOfRequesters;
      sel = IdxW'(cand);
      if (!found && req[sel]) begin
        found       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Non-preemptive N-way bus arbiter, fixed priority or round-robin.
// Define ARBITER_ASSERT_EN to compile in simulation-only consistency checks.
module bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NumOfRequesters = 4,
  parameter int unsigned RoundRobin      = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NumOfRequesters-1:0] REQ,
  output logic [NumOfRequesters-1:0] ACCESS
);

  localparam int unsigned IdxW = idx_width(NumOfRequesters);

  logic [NumOfRequesters-1:0] access_d;
  logic [NumOfRequesters-1:0] winner;
  logic [IdxW-1:0]            start;
  logic [IdxW-1:0]            winner_idx;
  logic                       held;
  logic                       regrant;

  // A released owner has REQ low, so it drops out of the candidates by itself.
  assign held    = |(ACCESS & REQ);
  assign regrant = !held && |REQ;

  arbiter_prio_sel #(
    .NumOfRequesters(NumOfRequesters),
    .IdxW           (IdxW)
  ) u_prio_sel (
    .req       (REQ),
    .start     (start),
    .winner    (winner),
    .winner_idx(winner_idx)
  );

  always_comb begin
    access_d = winner;
    if (held) access_d = ACCESS;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) ACCESS <= '0;
    else        ACCESS <= access_d;
  end

  if (RoundRobin != 0) begin : g_rr
    logic [IdxW-1:0] last_q;

    always_ff @(posedge CLK) begin
      if (!RST_N)       last_q <= IdxW'(NumOfRequesters - 1);
      else if (regrant) last_q <= winner_idx;
    end

    assign start = (last_q == IdxW'(NumOfRequesters - 1)) ? '0 : last_q + 1'b1;
  end else begin : g_fixed
    logic unused_rr;
    assign start     = '0;
    assign unused_rr = ^{winner_idx, regrant};
  end

`ifdef ARBITER_ASSERT_EN
  logic [NumOfRequesters-1:0] req_smp;
  logic [NumOfRequesters-1:0] access_prev;
  logic                       held_smp;

  always_ff @(posedge CLK) begin
    req_smp     <= REQ;
    access_prev <= ACCESS;
    held_smp    <= RST_N && |(ACCESS & REQ);
  end

  always @(negedge CLK) begin
    if (!onehot_or_zero(64'(ACCESS))) $error("ACCESS not one-hot: %b", ACCESS);
    if ((ACCESS & ~req_smp) != '0) $error("ACCESS %b without REQ %b", ACCESS, req_smp);
    if (RoundRobin != 0 && held_smp && ACCESS != access_prev)
      $error("owner switched while held: %b -> %b", access_prev, ACCESS);
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Checks fixed-priority and round-robin arbiter instances against a queue-free
// owner/last reference model with directed and random request patterns.
module tb_bus_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] acc_fp;
  logic [N-1:0] acc_rr;

  int tests = 0;
  int fails = 0;

  // Reference state: current owner index (-1 when idle) and last round-robin winner.
  int own_fp = -1;
  int own_rr = -1;
  int last_rr = N - 1;

  always #5 clk = ~clk;

  bus_arbiter #(.NumOfRequesters(N), .RoundRobin(0)) u_fp (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .ACCESS(acc_fp)
  );

  bus_arbiter #(.NumOfRequesters(N), .RoundRobin(1)) u_rr (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .ACCESS(acc_rr)
  );

  function automatic int pick(input logic [N-1:0] r, input int first);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (first + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] vec_of(input int owner);
    logic [N-1:0] v;
    v = '0;
    if (owner >= 0) v[owner] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rn);
    if (!rn) begin
      own_fp  = -1;
      own_rr  = -1;
      last_rr = N - 1;
    end else begin
      if (!(own_fp >= 0 && r[own_fp])) own_fp = pick(r, 0);
      if (!(own_rr >= 0 && r[own_rr])) begin
        own_rr = pick(r, (last_rr + 1) % N);
        if (own_rr >= 0) last_rr = own_rr;
      end
    end
  endtask

  // Drive inputs, take one edge, then compare both instances with the model.
  task automatic step(input logic [N-1:0] r, input logic rn, input logic glitch);
    req   = r;
    rst_n = rn;
    if (glitch) begin
      #1 req = '0;
      #1 req = r;
    end
    @(posedge clk);
    model_edge(r, rn);
    #1;
    chk("fixed_model", acc_fp, vec_of(own_fp));
    chk("rr_model", acc_rr, vec_of(own_rr));
  endtask

  initial begin
    @(negedge clk);
    // Reset with everyone requesting
    step(4'b1111, 1'b0, 1'b0);
    chk("reset_fp", acc_fp, 4'b0000);
    chk("reset_rr", acc_rr, 4'b0000);

    // Fixed priority basics
    step(4'b0110, 1'b1, 1'b0);
    chk("fp_0110", acc_fp, 4'b0010);
    chk("rr_first_0110", acc_rr, 4'b0010);
    step(4'b0100, 1'b1, 1'b0);
    chk("fp_0100", acc_fp, 4'b0100);
    step(4'b0000, 1'b1, 1'b0);
    chk("fp_idle", acc_fp, 4'b0000);

    // Hold: owner 1 keeps the bus against a higher-priority request
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    chk("fp_hold", acc_fp, 4'b0010);
    step(4'b0011, 1'b1, 1'b1);
    chk("fp_hold_glitch", acc_fp, 4'b0010);
    step(4'b0001, 1'b1, 1'b0);
    chk("fp_handover", acc_fp, 4'b0001);

    // Round-robin rotation from a fresh reset
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rr_rot0", acc_rr, 4'b0001);
    step(4'b1110, 1'b1, 1'b0);
    chk("rr_rot1", acc_rr, 4'b0010);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1101, 1'b1, 1'b0);
    chk("rr_rot2", acc_rr, 4'b0100);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1011, 1'b1, 1'b0);
    chk("rr_rot3", acc_rr, 4'b1000);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0111, 1'b1, 1'b0);
    chk("rr_wrap0", acc_rr, 4'b0001);

    // Wrap/fairness starting from LAST = N-1
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    chk("rr_1010", acc_rr, 4'b0010);
    step(4'b1000, 1'b1, 1'b0);
    chk("rr_1000", acc_rr, 4'b1000);
    step(4'b0010, 1'b1, 1'b0);
    chk("rr_0010", acc_rr, 4'b0010);

    // Mid-grant reset
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("mid_pre", acc_rr, 4'b0100);
    step(4'b0110, 1'b0, 1'b0);
    chk("mid_rst_fp", acc_fp, 4'b0000);
    chk("mid_rst_rr", acc_rr, 4'b0000);
    step(4'b0110, 1'b1, 1'b0);
    chk("mid_after_fp", acc_fp, 4'b0010);
    chk("mid_after_rr", acc_rr, 4'b0010);

    // Random traffic, biased towards holding requests
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] r;
      logic         rn;
      r  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) r = r | vec_of(own_rr);
      rn = ($urandom_range(0, 39) != 0);
      step(r, rn, 1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
